// File: rtl/output_display_unit.sv
// Seven-segment display driver: captures a 32-bit value on a write strobe, converts it
// to BCD with a one-shift-per-clock double-dabble FSM, then latches digits, sign and overflow.
module output_display_unit #(
    parameter int DIGITS = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flagOut,
    input  logic [31:0]           dataOut,
    output logic                  busy,
    output logic                  done,
    output logic [39:0]           bcd,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  signLed,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [6:0]          SEG_BLANK = 7'b1111111;
    localparam logic [7*DIGITS-1:0] SEG_RESET =
        ({(7*DIGITS){1'b1}} << 7) | (7*DIGITS)'(7'b1000000);

    state_t        state_r;
    logic [31:0]   shift_r;
    logic [39:0]   accum_r;
    logic [4:0]    count_r;
    logic          sign_r;

    logic [31:0]          magnitude_s;
    logic                 negative_s;
    logic [39:0]          adjusted_s;
    logic [7*DIGITS-1:0]  segNext_s;
    logic                 ovfNext_s;

    function automatic logic [39:0] dabbleAdjust(input logic [39:0] acc);
        logic [39:0] r;
        r = acc;
        for (int i = 0; i < 10; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit shows blank
    function automatic logic [6:0] encodeDigit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Magnitude of the incoming word; 32'h80000000 negates to itself, read as unsigned 2^31
    always_comb begin
        negative_s = SIGNED && dataOut[31];
        if (negative_s) begin
            magnitude_s = ~dataOut + 32'd1;
        end else begin
            magnitude_s = dataOut;
        end
    end

    assign adjusted_s = dabbleAdjust(accum_r);

    // Segment patterns with leading-zero blanking, and overflow from the undisplayed digits
    always_comb begin : segCalc
        logic [10:0] nzFrom;
        nzFrom     = 11'd0;
        segNext_s  = SEG_RESET;
        ovfNext_s  = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            nzFrom[i] = nzFrom[i+1] | (accum_r[4*i +: 4] != 4'd0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if ((i == 0) || nzFrom[i]) begin
                segNext_s[7*i +: 7] = encodeDigit(accum_r[4*i +: 4]);
            end else begin
                segNext_s[7*i +: 7] = SEG_BLANK;
            end
        end
        for (int i = DIGITS; i < 10; i++) begin
            ovfNext_s = ovfNext_s | (accum_r[4*i +: 4] != 4'd0);
        end
    end

    // Conversion FSM; displayed outputs only change in UPDATE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            shift_r  <= 32'd0;
            accum_r  <= 40'd0;
            count_r  <= 5'd0;
            sign_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= 40'd0;
            segments <= SEG_RESET;
            signLed  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flagOut) begin
                        shift_r <= magnitude_s;
                        sign_r  <= negative_s;
                        accum_r <= 40'd0;
                        count_r <= 5'd0;
                        busy    <= 1'b1;
                        state_r <= CONVERT;
                    end
                end
                CONVERT: begin
                    accum_r <= {adjusted_s[38:0], shift_r[31]};
                    shift_r <= {shift_r[30:0], 1'b0};
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        state_r <= UPDATE;
                    end
                end
                UPDATE: begin
                    bcd      <= accum_r;
                    signLed  <= sign_r;
                    overflow <= ovfNext_s;
                    segments <= segNext_s;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/output_display_unit.md
Name: output_display_unit

Overview:
- Sits directly downstream of the datapath's OUT value (the display value) and drives the board's seven-segment displays.
- On a write strobe it captures the 32-bit word and converts it to 10 BCD digits with a sequential double-dabble FSM, one shift per clock.
- It then latches the low DIGITS digits as active-low segment patterns, with leading-zero blanking, a sign LED and an overflow LED.
- The display holds the last converted value until the next accepted strobe.

Parameters:
- DIGITS, 4: number of seven-segment digits driven; legal range 1..10.
- SIGNED, 1: 1 = treat the input as two's complement and display the magnitude with signLed; 0 = treat the input as unsigned.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flagOut  in  1  write strobe from control; sampled only in IDLE.
- dataOut  in  32  value to display; sampled in the same cycle as an accepted flagOut.
- busy  out  1  high while a conversion is in progress (states CONVERT and UPDATE).
- done  out  1  one-cycle pulse when the displayed value has been updated.
- bcd  out  40  latched 10-digit BCD result; digit i is at [4i+3:4i]; digit 0 is least significant.
- segments  out  7*DIGITS  digit i is at [7i+6:7i], bit order {g,f,e,d,c,b,a}, active-low.
- signLed  out  1  high when the latched value is negative (SIGNED=1 only).
- overflow  out  1  high when the latched magnitude is >= 10^DIGITS.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset has priority over every other event, including a conversion in progress.
- Reset values:
  - state IDLE; busy=0, done=0, bcd=0, signLed=0, overflow=0.
  - segments show "0" on digit 0 (7'b1000000) and blank (7'b1111111) on all other digits.
  - Any partial conversion is discarded.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - If flagOut=1, capture the magnitude into a 32-bit shift register.
  - Magnitude = two's-complement negation of dataOut if SIGNED=1 and dataOut[31]=1; otherwise dataOut.
  - 32'h80000000 gives magnitude 2147483648 and must not overflow the register.
  - Store the sign, clear the 40-bit BCD accumulator, clear the 5-bit iteration counter, go to CONVERT.
- CONVERT, once per cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then {accumulator, shift register} shifts left by one.
  - The counter increments; after the 32nd shift go to UPDATE.
- UPDATE:
  - Latch the accumulator into bcd, the stored sign into signLed, and overflow (any nonzero digit at index >= DIGITS).
  - Recompute segments, pulse done for exactly this one cycle, then return to IDLE.
- Latency: if flagOut is sampled at edge E, bcd, segments, signLed and overflow change at edge E+33. done is high for the cycle following edge E+33. busy is high from edge E+1 through edge E+33.
- Back-to-back: the cycle after done, the FSM is in IDLE and a new flagOut is accepted.
- flagOut while busy: ignored, not queued. dataOut changes during a conversion have no effect.
- Outputs are stable between UPDATEs; no intermediate value is ever visible on bcd or segments.
- Digit encoding (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Leading-zero blanking: digit i (i>0) is blank when digits i..9 of bcd are all zero. Digit 0 is never blank.
- Overflow: the low DIGITS digits still display, unblanked as required by the higher nonzero digits. overflow=1.
- SIGNED=0: signLed is held at 0 and dataOut[31] is an ordinary magnitude bit.

Test Plan:
1. Reset, then flagOut with dataOut=0 -> after 33 edges: done pulse; bcd=0; segments digit0=1000000, digits 1..3 blank; signLed=0; overflow=0.
2. dataOut=1234 -> digits 3..0 = 1,2,3,4; bcd=40'h1234; overflow=0; busy high for exactly 33 cycles; done high for exactly 1 cycle.
3. SIGNED=1, dataOut=32'hFFFFFFC7 (-57) -> bcd=40'h57; digits 1,0 = 5,7; digits 2..3 blank; signLed=1. SIGNED=1, dataOut=32'h80000000 -> bcd=40'h2147483648, signLed=1, overflow=1. SIGNED=0, dataOut=32'hFFFFFFFF -> bcd=40'h4294967295, signLed=0, overflow=1 (DIGITS=4).
4. DIGITS=4, dataOut=123456 -> digits 3..0 = 3,4,5,6; overflow=1. Then dataOut=7 -> digit 0 = 7, digits 1..3 blank; overflow=0.
5. flagOut with dataOut=99, then flagOut again with dataOut=55 at cycle 10 of the conversion -> second strobe ignored; result 99. A strobe in the cycle after done with dataOut=55 -> result 55 after 33 edges.
6. Convert 1234, then start 5678 and assert reset at conversion cycle 20 -> outputs return to reset values the next edge; no done pulse. The next accepted strobe with 42 -> digits 1,0 = 4,2.
